analog_switch_seq: RTL
======================

ANALOG_SWITCH_SEQ -- requirements
Module: analog_switch_seq

Interface
REQ-001 Parameter DEAD_CYCLES, default 4, break-to-make dead time in clk cycles; legal range 1..255.
REQ-002 Parameter EXCL_MASK, default 6'b000011, set of switches of which at most one may be closed at a time.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered this cycle.
REQ-006 cmd_mask  input  6  requested closed-switch set, bit i drives analog pad ua[i].
REQ-007 cmd_ready  output  1  command can be accepted this cycle.
REQ-008 sw_en  output  6  registered switch gate enables, 1 = switch closed.
REQ-009 busy  output  1  sequence in progress.
REQ-010 done  output  1  one-cycle pulse when sw_en reaches the commanded set.
REQ-011 err  output  1  one-cycle pulse when a command is rejected.

Function
REQ-012 The block SHALL be an FSM with states IDLE, DEAD and an 8-bit dead-time counter.
REQ-013 cmd_ready SHALL equal (state==IDLE) and not rst; busy SHALL equal (state!=IDLE).
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; cmd_mask is captured into a pending register at that edge.
REQ-015 Commands offered while cmd_ready=0 SHALL be ignored with no side effect; the source holds cmd_valid.
REQ-016 Rejection: if popcount(cmd_mask & EXCL_MASK) > 1 at acceptance, sw_en and state SHALL be unchanged, and err SHALL be 1 for exactly the cycle after the accepting edge.
REQ-017 No-op: if cmd_mask equals sw_en, the block SHALL stay in IDLE, leave sw_en unchanged, and pulse done the next cycle.
REQ-018 Make-only: if cmd_mask is a strict superset of sw_en (no bit opens), sw_en SHALL become cmd_mask at the accepting edge, state SHALL stay IDLE, and done SHALL pulse the next cycle.
REQ-019 Break-before-make: if any closed bit opens, then at the accepting edge sw_en SHALL become sw_en & cmd_mask, state SHALL go to DEAD, and the counter SHALL load DEAD_CYCLES-1.
REQ-020 In DEAD, each edge with counter!=0 SHALL decrement the counter; the edge with counter==0 SHALL set sw_en to the pending mask, return to IDLE, and pulse done.
REQ-021 Consequently, the intermediate set SHALL be visible for exactly DEAD_CYCLES cycles; a newly closing switch SHALL never be enabled while any opening switch is still enabled.
REQ-022 sw_en SHALL never hold more than one EXCL_MASK bit set, in any cycle.
REQ-023 done and err SHALL never be 1 in the same cycle; each SHALL be a single-cycle pulse.
REQ-024 The earliest next acceptance SHALL be the cycle done is high (back-to-back commands allowed).
REQ-025 cmd_mask = 0 SHALL follow REQ-019 when any switch is closed; it is never rejected.

Reset
REQ-026 On a rising edge with rst=1 the block SHALL set sw_en=0, state=IDLE, counter=0, pending=0, done=0, err=0, regardless of state, including mid-DEAD.
REQ-027 rst SHALL take priority over a simultaneous cmd_valid; that command is not accepted.
REQ-028 After rst deasserts, cmd_ready SHALL be 1 in the first cycle.

Verification
REQ-029 Defaults; from reset, send 6'b000100 -> sw_en=000100 after the accepting edge, done pulse the next cycle, busy never set.
REQ-030 sw_en=000101, send 6'b000110 -> sw_en=000100 for exactly 4 cycles, then 000110, done pulse, busy high for 4 cycles, cmd_ready low during that time.
REQ-031 Send 6'b000011 with sw_en=000000 -> err pulse for 1 cycle, sw_en stays 000000, no done pulse.
REQ-032 Assert rst in the 2nd DEAD cycle of the REQ-030 sequence -> sw_en=000000 and busy=0 after that edge; cmd_ready=1 the cycle after rst falls.
REQ-033 Hold cmd_valid with 6'b100000 throughout the REQ-030 DEAD period -> it is accepted only in the done cycle; the sequence then runs to sw_en=100000 via 4 cycles of 000000.
REQ-034 Random stream of commands -> a scoreboard checks REQ-021/REQ-022 every cycle, and checks that every accepted command ends in exactly one done pulse or one err pulse.

Source files
------------

// File: rtl/analog_switch_seq.sv
// Break-before-make sequencer for six analog pad switches.
// Opening switches drop first; new closings wait out a dead time.
module analog_switch_seq #(
   parameter int unsigned DEAD_CYCLES = 4,
   parameter logic [5:0]  EXCL_MASK   = 6'b000011
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [5:0] cmd_mask,
   output logic       cmd_ready,
   output logic [5:0] sw_en,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic {
      IDLE = 1'b0,
      DEAD = 1'b1
   } state_e;

   localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);

   if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead
      $error("DEAD_CYCLES out of range 1..255");
   end

   state_e     state_q;
   logic [7:0] cnt_q;
   logic [5:0] pend_q;
   logic [5:0] sw_q;
   logic       done_q;
   logic       err_q;

   logic [5:0] excl_hit;
   logic [2:0] excl_cnt;
   logic       excl_bad;
   logic       opens;
   logic       accept;

   always_comb begin
      excl_hit = cmd_mask & EXCL_MASK;
      excl_cnt = '0;
      for (int i = 0; i < 6; i++) begin
         excl_cnt = excl_cnt + {2'b00, excl_hit[i]};
      end
   end

   assign excl_bad  = excl_cnt > 3'd1;
   assign opens     = |(sw_q & ~cmd_mask);
   assign cmd_ready = (state_q == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         sw_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  pend_q <= cmd_mask;
                  if (excl_bad) begin
                     err_q <= 1'b1;
                  end else if (!opens) begin
                     // no-op or pure make: nothing to break first
                     sw_q   <= cmd_mask;
                     done_q <= 1'b1;
                  end else begin
                     sw_q    <= sw_q & cmd_mask;
                     cnt_q   <= DEAD_LOAD;
                     state_q <= DEAD;
                  end
               end
            end
            DEAD: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  sw_q    <= pend_q;
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign sw_en = sw_q;
   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign err   = err_q;

endmodule
